alu_shift_mul: RTL and testbench
================================

# alu_shift_mul

Parametrised execute-stage datapath for the ARM-model CPU: operand muxes, barrel shifter, 16-op ALU, and an iterative multiplier (MUL/MLA). The F result register and the NZCV flags register are owned by this block. Single-cycle ALU operations complete on the next active edge. Multiplies run WIDTH cycles, with a busy/done handshake to the control unit.

## Interface
- WIDTH, 32: datapath width. Power of two, 8 or more.
- MUL_EN, 1: 0 removes the multiplier. MUL and MLA then behave as ALU mode.

- clk  in  1  single clock. All state updates on the falling edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request. Accepted on an edge where busy=0.
- op_mode  in  2  00 ALU, 01 MUL, 10 MLA, 11 treated as ALU.
- ALU_OP  in  4  ARM data-processing opcode, 0000 AND … 1111 MVN, standard ARM order.
- SHIFT_OP  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX. Others pass data through.
- Shift_Data  in  WIDTH  shifter input.
- Shift_Num  in  8  shift amount.
- A_New  in  WIDTH  register operand A.
- PC  in  WIDTH  program counter.
- Acc  in  WIDTH  MLA addend.
- imm24  in  24  branch offset.
- ALU_A_s  in  1  1: A=PC, else A=A_New.
- ALU_B_s  in  1  1: B=sign-extended imm24 shifted left 2 (truncated/extended to WIDTH), else B=Shift_Out.
- S  in  1  update NZCV.
- LF  in  1  write F.
- Shift_Out  out  WIDTH  combinational shifter result.
- F  out  WIDTH  result register.
- NZCV  out  4  flags register, N=bit3 … V=bit0.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- **Shifter** uses C=NZCV[1] as carry-in.
  - Shift_Num=0: data passes through, carry=C.
  - LSL n<WIDTH: carry=data[WIDTH-n]. n=WIDTH: result 0, carry data[0]. n>WIDTH: result 0, carry 0.
  - LSR: mirror of LSL. n=WIDTH gives carry data[WIDTH-1]; n>WIDTH gives result 0, carry 0.
  - ASR n≥WIDTH: all result bits and the carry equal data[WIDTH-1].
  - ROR: amount is n mod WIDTH. Carry is result[WIDTH-1]. n a nonzero multiple of WIDTH gives the unchanged value with carry data[WIDTH-1].
  - RRX (Shift_Num ignored): result {C, data[WIDTH-1:1]}, carry data[0].
- **ALU flags**
  - Arithmetic ops (SUB RSB ADD ADC SBC RSC CMP CMN): C = carry out (subtract: C = NOT borrow). V = signed overflow.
  - Logical ops: C = shifter carry, V held.
  - N and Z are taken from the WIDTH-bit result.
  - TST/TEQ/CMP/CMN still produce F_new. LF decides whether F is written.
- **ALU mode.** On an accepting edge: F←F_new if LF, NZCV←new if S. done=1 for the following cycle. busy stays 0.
- **MUL/MLA**
  - On accept, latch A and B (after the muxes), Acc, S and LF. Set busy=1 and clear the counter.
  - Perform one radix-2 shift-add step per edge.
  - At the WIDTH-th edge after accept, the low WIDTH bits of A·B (+Acc for MLA) are produced. F←product if the latched LF. If the latched S: N,Z updated, C,V held.
  - On that same edge busy←0 and done←1.
- start while busy=1 is ignored. It is not queued.

## Timing
- Reset values: F=0, NZCV=0, busy=0, done=0, counter=0, multiplier registers=0.
- Rst asserted mid-multiply aborts immediately. F and NZCV go to 0. No done pulse.
- ALU latency: 1 edge. Multiply latency: WIDTH edges from accept to result.
- done is high for exactly one cycle and is cleared on the next edge, unless a new ALU op is accepted on that edge.
- start on the same edge that busy falls is not accepted. The earliest new accept is the following edge.
- Back-to-back ALU ops: one accept per edge, with flags chained. The carry-in is the NZCV value registered by the previous op.

## Test plan
- Rst pulse mid-stream → F=0, NZCV=0000, busy=0, done=0 asynchronously, before the next clk edge.
- ADD, A_New=0x7FFFFFFF, B=1 (no shift), S=LF=1 → after one edge F=0x80000000, NZCV=1001, done high one cycle.
- SUB, A=5, B=5, S=1 → F=0, NZCV=0110. Then ADC, A=0, B=0 → F=1 (carry-in used).
- MOV with LSL, Shift_Data=0x80000001, Shift_Num=1, S=1, prior V=1 → F=0x00000002, NZCV=0011. Repeat with RRX and C=1 → F=0xC0000000, C=1.
- MUL, A=0xFFFFFFFF, B=3, S=1, prior C=1 V=0 → busy for 32 edges, start during busy ignored, F=0xFFFFFFFD, NZCV=1010, single done pulse. MLA, 7·6+5 → F=47.
- MLA with Rst at edge 10 → busy=0, F=0, no done. Then ADD with ALU_A_s=1, PC=0x100, ALU_B_s=1, imm24=0xFFFFFF → F=0xFC.

Source files
------------

// File: rtl/alu_shift_mul.sv
// Execute stage: operand muxes, barrel shifter, 16-op ALU and radix-2 MUL/MLA; F and NZCV are owned here.
// Latency: ALU 1 falling edge, multiply WIDTH edges. Backpressure: start is ignored, not queued, while busy.
module alu_shift_mul #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [1:0]       op_mode,
    input  logic [3:0]       ALU_OP,
    input  logic [2:0]       SHIFT_OP,
    input  logic [WIDTH-1:0] Shift_Data,
    input  logic [7:0]       Shift_Num,
    input  logic [WIDTH-1:0] A_New,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Acc,
    input  logic [23:0]      imm24,
    input  logic             ALU_A_s,
    input  logic             ALU_B_s,
    input  logic             S,
    input  logic             LF,
    output logic [WIDTH-1:0] Shift_Out,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       NZCV,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    // Rotate amount is n mod WIDTH; for WIDTH > 256 the whole 8-bit amount already is.
    localparam int RW = (CW < 8) ? CW : 8;

    logic [WIDTH-1:0] r_f;
    logic [3:0]       r_nzcv;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic             r_m_s;
    logic             r_m_lf;

    logic                    w_c_in;
    logic                    w_sh_nz;
    logic [WIDTH:0]          w_lsl;
    logic [WIDTH:0]          w_lsr;
    logic signed [WIDTH:0]   w_asr;
    logic [2*WIDTH-1:0]      w_ror2;
    logic [WIDTH-1:0]        w_sh_res;
    logic                    w_sh_c;

    assign w_c_in  = r_nzcv[1];
    assign w_sh_nz = (Shift_Num != 8'd0);
    // The extra bit beside the data catches the last bit shifted out.
    assign w_lsl   = {1'b0, Shift_Data} << Shift_Num;
    assign w_lsr   = {Shift_Data, 1'b0} >> Shift_Num;
    assign w_asr   = $signed({Shift_Data, 1'b0}) >>> Shift_Num;
    assign w_ror2  = {Shift_Data, Shift_Data} >> Shift_Num[RW-1:0];

    always_comb begin
        w_sh_res = Shift_Data;
        w_sh_c   = w_c_in;
        case (SHIFT_OP)
            3'b000: if (w_sh_nz) {w_sh_c, w_sh_res} = w_lsl;
            3'b001: if (w_sh_nz) {w_sh_res, w_sh_c} = w_lsr;
            3'b010: if (w_sh_nz) {w_sh_res, w_sh_c} = w_asr;
            3'b011: if (w_sh_nz) begin
                w_sh_res = w_ror2[WIDTH-1:0];
                w_sh_c   = w_ror2[WIDTH-1];
            end
            3'b100: begin
                w_sh_res = {w_c_in, Shift_Data[WIDTH-1:1]};
                w_sh_c   = Shift_Data[0];
            end
            default: ;
        endcase
    end

    assign Shift_Out = w_sh_res;

    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_imm = WIDTH'({{WIDTH{imm24[23]}}, imm24, 2'b00});
    assign w_a   = ALU_A_s ? PC : A_New;
    assign w_b   = ALU_B_s ? w_imm : w_sh_res;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;

    // Every subtract is x + ~y + carry, so one adder covers all eight arithmetic ops.
    always_comb begin
        w_x     = w_a;
        w_y     = w_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_res   = '0;
        case (ALU_OP)
            4'h0: w_res = w_a & w_b;
            4'h1: w_res = w_a ^ w_b;
            4'h2: begin w_y = ~w_b; w_cin = 1'b1; w_arith = 1'b1; end
            4'h3: begin w_x = w_b; w_y = ~w_a; w_cin = 1'b1; w_arith = 1'b1; end
            4'h4: w_arith = 1'b1;
            4'h5: begin w_cin = w_c_in; w_arith = 1'b1; end
            4'h6: begin w_y = ~w_b; w_cin = w_c_in; w_arith = 1'b1; end
            4'h7: begin w_x = w_b; w_y = ~w_a; w_cin = w_c_in; w_arith = 1'b1; end
            4'h8: w_res = w_a & w_b;
            4'h9: w_res = w_a ^ w_b;
            4'hA: begin w_y = ~w_b; w_cin = 1'b1; w_arith = 1'b1; end
            4'hB: w_arith = 1'b1;
            4'hC: w_res = w_a | w_b;
            4'hD: w_res = w_b;
            4'hE: w_res = w_a & ~w_b;
            default: w_res = ~w_b;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        if (w_arith) w_res = w_sum[WIDTH-1:0];
        w_flags[3] = w_res[WIDTH-1];
        w_flags[2] = (w_res == '0);
        w_flags[1] = w_arith ? w_sum[WIDTH] : w_sh_c;
        w_flags[0] = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                             : r_nzcv[0];
    end

    logic             w_is_mul;
    logic [WIDTH-1:0] w_prod_nxt;
    logic             w_last;

    assign w_is_mul   = MUL_EN && ((op_mode == 2'b01) || (op_mode == 2'b10));
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(negedge clk or posedge Rst) begin
        if (Rst) begin
            r_f      <= '0;
            r_nzcv   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_m_s    <= 1'b0;
            r_m_lf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_m_lf) r_f <= w_prod_nxt;
                    if (r_m_s)  r_nzcv[3:2] <= {w_prod_nxt[WIDTH-1], (w_prod_nxt == '0)};
                end
            end else if (start) begin
                if (w_is_mul) begin
                    r_mcand  <= w_a;
                    r_mplier <= w_b;
                    r_prod   <= (op_mode == 2'b10) ? Acc : '0;
                    r_m_s    <= S;
                    r_m_lf   <= LF;
                    r_cnt    <= '0;
                    r_busy   <= 1'b1;
                end else begin
                    if (LF) r_f <= w_res;
                    if (S)  r_nzcv <= w_flags;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign F    = r_f;
    assign NZCV = r_nzcv;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_alu_shift_mul.sv
// Directed bench for alu_shift_mul: shifter boundaries, ALU flags, MUL/MLA handshake, async reset.
module tb_alu_shift_mul;

    logic        clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [1:0]  op_mode;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [31:0] A_New;
    logic [31:0] PC;
    logic [31:0] Acc;
    logic [23:0] imm24;
    logic        ALU_A_s;
    logic        ALU_B_s;
    logic        S;
    logic        LF;
    logic [31:0] Shift_Out;
    logic [31:0] F;
    logic [3:0]  NZCV;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;
    int done_cnt;

    localparam logic [3:0] OP_SUB = 4'h2, OP_ADD = 4'h4, OP_ADC = 4'h5, OP_CMP = 4'hA, OP_MOV = 4'hD;
    localparam logic [2:0] SH_LSL = 3'd0, SH_LSR = 3'd1, SH_ASR = 3'd2, SH_ROR = 3'd3, SH_RRX = 3'd4;

    alu_shift_mul #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .Rst(Rst), .start(start), .op_mode(op_mode), .ALU_OP(ALU_OP),
        .SHIFT_OP(SHIFT_OP), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num),
        .A_New(A_New), .PC(PC), .Acc(Acc), .imm24(imm24), .ALU_A_s(ALU_A_s),
        .ALU_B_s(ALU_B_s), .S(S), .LF(LF), .Shift_Out(Shift_Out), .F(F),
        .NZCV(NZCV), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // DUT state moves on the falling edge; sample 1 time unit after it.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [2:0] sop, input logic [7:0] sn, input logic s_i, input logic lf_i);
        op_mode = 2'b00; ALU_OP = op; A_New = a; Shift_Data = sd;
        SHIFT_OP = sop; Shift_Num = sn; S = s_i; LF = lf_i;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mul_go(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] acc_i);
        op_mode = mode; A_New = a; Shift_Data = b; SHIFT_OP = SH_LSL; Shift_Num = 8'd0;
        Acc = acc_i; S = 1'b1; LF = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; op_mode = 2'b00; ALU_OP = 4'h0; SHIFT_OP = 3'd0;
        Shift_Data = '0; Shift_Num = '0; A_New = '0; PC = '0; Acc = '0; imm24 = '0;
        ALU_A_s = 1'b0; ALU_B_s = 1'b0; S = 1'b0; LF = 1'b0;
        #3;
        chk("rst_F", F, 32'h0);
        chk("rst_NZCV", {28'd0, NZCV}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        #4 Rst = 1'b0;

        alu(OP_ADD, 32'h7FFF_FFFF, 32'h1, SH_LSL, 8'd0, 1'b1, 1'b1);
        chk("add_ovf_F", F, 32'h8000_0000);
        chk("add_ovf_NZCV", {28'd0, NZCV}, 32'h9);
        chk("add_done", {31'd0, done}, 32'h1);
        tick();
        chk("add_done_clr", {31'd0, done}, 32'h0);

        alu(OP_SUB, 32'd5, 32'd5, SH_LSL, 8'd0, 1'b1, 1'b1);
        chk("sub_F", F, 32'h0);
        chk("sub_NZCV", {28'd0, NZCV}, 32'h6);
        alu(OP_ADC, 32'd0, 32'd0, SH_LSL, 8'd0, 1'b1, 1'b1);
        chk("adc_F", F, 32'h1);
        chk("adc_NZCV", {28'd0, NZCV}, 32'h0);

        alu(OP_ADD, 32'h7FFF_FFFF, 32'h1, SH_LSL, 8'd0, 1'b1, 1'b1);
        alu(OP_MOV, 32'd0, 32'h8000_0001, SH_LSL, 8'd1, 1'b1, 1'b1);
        chk("lsl1_F", F, 32'h0000_0002);
        chk("lsl1_NZCV", {28'd0, NZCV}, 32'h3);
        alu(OP_MOV, 32'd0, 32'h8000_0001, SH_RRX, 8'd7, 1'b1, 1'b1);
        chk("rrx_F", F, 32'hC000_0000);
        chk("rrx_NZCV", {28'd0, NZCV}, 32'hB);
        alu(OP_MOV, 32'd0, 32'h0000_0001, SH_LSL, 8'd32, 1'b1, 1'b1);
        chk("lsl32_F", F, 32'h0);
        chk("lsl32_NZCV", {28'd0, NZCV}, 32'h7);
        alu(OP_MOV, 32'd0, 32'hFFFF_FFFF, SH_LSL, 8'd33, 1'b1, 1'b1);
        chk("lsl33_NZCV", {28'd0, NZCV}, 32'h5);
        alu(OP_MOV, 32'd0, 32'h8000_0000, SH_LSR, 8'd32, 1'b1, 1'b1);
        chk("lsr32_F", F, 32'h0);
        chk("lsr32_NZCV", {28'd0, NZCV}, 32'h7);
        alu(OP_MOV, 32'd0, 32'h8000_0000, SH_ASR, 8'd40, 1'b1, 1'b1);
        chk("asr40_F", F, 32'hFFFF_FFFF);
        chk("asr40_NZCV", {28'd0, NZCV}, 32'hB);
        alu(OP_MOV, 32'd0, 32'h8000_0000, SH_ROR, 8'd32, 1'b1, 1'b1);
        chk("ror32_F", F, 32'h8000_0000);
        chk("ror32_NZCV", {28'd0, NZCV}, 32'hB);
        alu(OP_MOV, 32'd0, 32'h0000_0007, SH_ROR, 8'd4, 1'b1, 1'b1);
        chk("ror4_F", F, 32'h7000_0000);
        chk("ror4_NZCV", {28'd0, NZCV}, 32'h1);

        SHIFT_OP = SH_LSR; Shift_Num = 8'd1; Shift_Data = 32'h8000_0000;
        #1;
        chk("comb_lsr1", Shift_Out, 32'h4000_0000);

        alu(OP_ADD, 32'd1, 32'd1, SH_LSL, 8'd0, 1'b1, 1'b0);
        chk("lf0_F", F, 32'h7000_0000);
        chk("lf0_NZCV", {28'd0, NZCV}, 32'h0);
        alu(OP_CMP, 32'd3, 32'd5, SH_LSL, 8'd0, 1'b1, 1'b0);
        chk("cmp_F", F, 32'h7000_0000);
        chk("cmp_NZCV", {28'd0, NZCV}, 32'h8);

        alu(OP_SUB, 32'd5, 32'd5, SH_LSL, 8'd0, 1'b1, 1'b1);
        mul_go(2'b01, 32'hFFFF_FFFF, 32'd3, 32'd0);
        chk("mul_busy_acc", {31'd0, busy}, 32'h1);
        chk("mul_no_done_acc", {31'd0, done}, 32'h0);
        op_mode = 2'b00; ALU_OP = OP_MOV; Shift_Data = 32'h1234_5678; S = 1'b1; LF = 1'b1;
        start = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        start = 1'b0;
        chk("mul_busy_edges", busy_cnt, 32'd31);
        chk("mul_early_done", done_cnt, 32'd0);
        chk("mul_start_ignored", F, 32'h0);
        tick();
        chk("mul_F", F, 32'hFFFF_FFFD);
        chk("mul_NZCV", {28'd0, NZCV}, 32'hA);
        chk("mul_busy_end", {31'd0, busy}, 32'h0);
        chk("mul_done", {31'd0, done}, 32'h1);
        tick();
        chk("mul_done_clr", {31'd0, done}, 32'h0);

        mul_go(2'b10, 32'd7, 32'd6, 32'd5);
        for (int i = 0; i < 31; i++) tick();
        chk("mla_busy_pre", {31'd0, busy}, 32'h1);
        tick();
        chk("mla_F", F, 32'd47);
        chk("mla_NZCV", {28'd0, NZCV}, 32'h2);
        chk("mla_done", {31'd0, done}, 32'h1);

        tick();
        mul_go(2'b10, 32'd7, 32'd6, 32'd5);
        for (int i = 0; i < 9; i++) tick();
        chk("mla_rst_busy_pre", {31'd0, busy}, 32'h1);
        #2 Rst = 1'b1;
        #1;
        chk("arst_F", F, 32'h0);
        chk("arst_NZCV", {28'd0, NZCV}, 32'h0);
        chk("arst_busy", {31'd0, busy}, 32'h0);
        chk("arst_done", {31'd0, done}, 32'h0);
        #1 Rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("arst_no_done", done_cnt, 32'd0);
        chk("arst_F_hold", F, 32'h0);

        ALU_A_s = 1'b1; PC = 32'h100; ALU_B_s = 1'b1; imm24 = 24'hFF_FFFF;
        alu(OP_ADD, 32'd0, 32'd0, SH_LSL, 8'd0, 1'b1, 1'b1);
        chk("pc_imm_F", F, 32'h0000_00FC);
        chk("pc_imm_NZCV", {28'd0, NZCV}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
